// File: rtl/shared_mem_pkg.sv
// Shared types and defaults for the multi-master shared-memory front end.
package shared_mem_pkg;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BE_W        = DEF_DATA_W / 8;

    // Return-pipeline id field is sized for the largest supported master count (8).
    localparam int MAX_ID_W = 3;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_MASTERS);

    typedef struct packed {
        logic                valid;
        logic                is_read;
        logic [MAX_ID_W-1:0] id;
    } ret_ent_t;

endpackage

// File: rtl/shared_memory_arbiter_rr_arbiter.sv
// Combinational round-robin grant with lock override; the pointer register lives in the parent.
module rr_arbiter
    import shared_mem_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ID_W        = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   lock_valid,
    input  logic [ID_W-1:0]        lock_owner,
    input  logic [ID_W-1:0]        rr_ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_W-1:0]        winner
);

    logic found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        if (lock_valid) begin
            // Only the owner can be granted; an idle owner leaves everyone waiting.
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (req[j] && (ID_W'(j) == lock_owner)) begin
                    grant[j] = 1'b1;
                    winner   = ID_W'(j);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                for (int j = 0; j < NUM_MASTERS; j++) begin
                    if (!found && req[j] && (j == ((int'(rr_ptr) + k) % NUM_MASTERS))) begin
                        found    = 1'b1;
                        grant[j] = 1'b1;
                        winner   = ID_W'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Round-robin, lockable Avalon-MM front end for a single-port shared memory with 1-cycle read latency.
module shared_memory_arbiter
    import shared_mem_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BE_W        = DEF_BE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [BE_W-1:0]               mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);

    localparam int ID_W = id_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req, grant, rdv_onehot;
    logic [ID_W-1:0]        rr_ptr, lock_owner, winner;
    logic                   lock_valid, any_grant;
    logic [ADDR_W-1:0]      sel_addr;
    logic [BE_W-1:0]        sel_be;
    logic [DATA_W-1:0]      sel_wd;
    logic                   sel_wr, sel_lock;
    ret_ent_t [1:0]         ret_pipe;

    // Requests are masked in reset so waitrequest reads all-ones even with masters asserting.
    assign req = (m_read | m_write) & {NUM_MASTERS{reset_n}};

    rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .ID_W(ID_W)) u_arb (
        .req        (req),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .winner     (winner)
    );

    assign any_grant     = |grant;
    assign m_waitrequest = ~grant;

    always_comb begin
        sel_addr = '0;
        sel_be   = '0;
        sel_wd   = '0;
        sel_wr   = 1'b0;
        sel_lock = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (grant[j]) begin
                sel_addr = m_address[j*ADDR_W +: ADDR_W];
                sel_be   = m_byteenable[j*BE_W +: BE_W];
                sel_wd   = m_writedata[j*DATA_W +: DATA_W];
                sel_wr   = m_write[j];
                sel_lock = m_lock[j];
            end
        end
    end

    always_comb begin
        rdv_onehot = '0;
        for (int j = 0; j < NUM_MASTERS; j++)
            rdv_onehot[j] = (ret_pipe[1].id == MAX_ID_W'(j));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr          <= ID_W'(NUM_MASTERS - 1);
            lock_valid      <= 1'b0;
            lock_owner      <= '0;
            mem_address     <= '0;
            mem_byteenable  <= '0;
            mem_writedata   <= '0;
            mem_write       <= 1'b0;
            mem_chipselect  <= 1'b0;
            mem_clken       <= 1'b0;
            ret_pipe        <= '0;
            m_readdata      <= '0;
            m_readdatavalid <= '0;
        end else begin
            mem_clken      <= 1'b1;
            mem_chipselect <= any_grant;
            if (any_grant) begin
                mem_address    <= sel_addr;
                mem_byteenable <= sel_be;
                mem_writedata  <= sel_wd;
                mem_write      <= sel_wr;
                rr_ptr         <= winner;
                lock_valid     <= sel_lock;
                lock_owner     <= winner;
            end else begin
                mem_write <= 1'b0;
            end
            // Read-and-write together is treated as a write.
            ret_pipe[0] <= '{valid: any_grant, is_read: any_grant & ~sel_wr, id: MAX_ID_W'(winner)};
            ret_pipe[1] <= ret_pipe[0];
            m_readdatavalid <= '0;
            if (ret_pipe[1].valid && ret_pipe[1].is_read) begin
                m_readdata      <= mem_readdata;
                m_readdatavalid <= rdv_onehot;
            end
        end
    end

    a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!reset_n) (m_read & m_write) == '0);

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Scoreboard bench: a memory model behind the DUT, reads queued on acceptance and checked on readdatavalid.
module tb_shared_memory_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N*16-1:0] m_address;
    logic [N*4-1:0]  m_byteenable;
    logic [N-1:0]    m_read, m_write, m_lock;
    logic [N*32-1:0] m_writedata;
    logic [N-1:0]    m_waitrequest, m_readdatavalid;
    logic [31:0]     m_readdata;
    logic [15:0]     mem_address;
    logic [3:0]      mem_byteenable;
    logic            mem_chipselect, mem_write, mem_clken;
    logic [31:0]     mem_writedata, mem_readdata;

    shared_memory_arbiter #(.NUM_MASTERS(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata), .m_lock(m_lock),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Single-port memory, registered q.
    logic [31:0] mem_arr [0:255];
    logic [31:0] mem_q = '0;
    assign mem_readdata = mem_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem_arr[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_q <= mem_arr[mem_address[7:0]];
            end
        end
    end

    int n_chk = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    typedef struct { int id; logic [31:0] data; int acc; } sb_t;
    sb_t         sb[$];
    sb_t         e;
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_rd = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            chk("gnt_1hot", 64'($countones(~m_waitrequest) <= 1), 64'd1);
            if (m_readdatavalid != '0) begin
                if (sb.size() == 0) begin
                    chk("rdv_unexp", 64'(m_readdatavalid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdv_id", 64'(m_readdatavalid), 64'(2'b01 << e.id));
                    chk("rdv_data", 64'(m_readdata), 64'(e.data));
                    chk("rdv_lat", 64'(cyc - e.acc), 64'd2);
                    last_rd = m_readdata;
                end
            end
            for (int i = 0; i < N; i++) begin
                if ((m_read[i] | m_write[i]) && !m_waitrequest[i]) begin
                    if (m_write[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (m_byteenable[i*4 + b])
                                ref_mem[m_address[i*16 +: 8]][8*b +: 8] = m_writedata[i*32 + 8*b +: 8];
                    end else begin
                        sb.push_back('{i, ref_mem[m_address[i*16 +: 8]], cyc + 1});
                    end
                end
            end
        end
    end

    task automatic drv(input int m, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic lk);
        m_read[m] = rd;
        m_write[m] = wr;
        m_address[m*16 +: 16] = a;
        m_writedata[m*32 +: 32] = d;
        m_byteenable[m*4 +: 4] = be;
        m_lock[m] = lk;
    endtask

    // Returns #1 after the accepting edge with the request already dropped.
    task automatic issue(input int m, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drv(m, !wr, wr, a, d, be, 1'b0);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!m_waitrequest[m]) begin ok = 1'b1; break; end
        end
        if (!ok) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        m_read[m] = 1'b0;
        m_write[m] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic gnt(input string tag, input logic [N-1:0] exp_wr);
        @(negedge clk);
        chk(tag, 64'(m_waitrequest), 64'(exp_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    int last_w;

    initial begin
        reset_n = 1'b0;
        m_address = '0; m_byteenable = '0; m_read = '0; m_write = '0; m_writedata = '0; m_lock = '0;
        for (int i = 0; i < 256; i++) begin mem_arr[i] = 32'h0; ref_mem[i] = 32'h0; end
        mem_arr[1] = 32'hA1A1_0001;  ref_mem[1] = 32'hA1A1_0001;
        mem_arr[2] = 32'hB2B2_0002;  ref_mem[2] = 32'hB2B2_0002;
        mem_arr[32] = 32'h1122_3344; ref_mem[32] = 32'h1122_3344;

        // Reset state
        #12;
        chk("rst_wr", 64'(m_waitrequest), 64'h3);
        chk("rst_rdv", 64'(m_readdatavalid), 64'h0);
        chk("rst_rdata", 64'(m_readdata), 64'h0);
        chk("rst_cs", 64'(mem_chipselect), 64'h0);
        chk("rst_clken", 64'(mem_clken), 64'h0);
        chk("rst_addr", 64'(mem_address), 64'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("clken_up", 64'(mem_clken), 64'h1);
        chk("idle_cs", 64'(mem_chipselect), 64'h0);
        chk("idle_wr", 64'(m_waitrequest), 64'h3);

        // Full-word write then read back
        issue(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        chk("wr_cs", 64'(mem_chipselect), 64'h1);
        chk("wr_we", 64'(mem_write), 64'h1);
        chk("wr_addr", 64'(mem_address), 64'h10);
        chk("wr_data", 64'(mem_writedata), 64'hDEADBEEF);
        chk("wr_be", 64'(mem_byteenable), 64'hF);
        issue(0, 1'b0, 16'h0010, 32'h0, 4'hF);
        chk("rd_we", 64'(mem_write), 64'h0);
        chk("rd_cs", 64'(mem_chipselect), 64'h1);
        @(posedge clk); #1;
        chk("idle_cs2", 64'(mem_chipselect), 64'h0);
        chk("idle_addr_hold", 64'(mem_address), 64'h10);
        drain();
        chk("rd_back", 64'(last_rd), 64'hDEADBEEF);

        // Both masters streaming reads: grants alternate
        last_w = 0;
        @(posedge clk); #1;
        drv(0, 1'b1, 1'b0, 16'h0001, 32'h0, 4'hF, 1'b0);
        drv(1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b0);
        for (int k = 0; k < 8; k++) begin
            last_w = 1 - last_w;
            gnt("alt_gnt", 2'b11 ^ (2'b01 << last_w));
        end
        @(posedge clk); #1;
        m_read = '0;
        drain();

        // Lock held by M1; an idle owner keeps M0 blocked
        drv(1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b1);
        gnt("lock_a", 2'b01);
        @(posedge clk); #1;
        drv(0, 1'b1, 1'b0, 16'h0001, 32'h0, 4'hF, 1'b0);
        gnt("lock_b", 2'b01);
        @(posedge clk); #1;
        drv(1, 1'b0, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b0);
        gnt("lock_idle", 2'b11);
        @(posedge clk); #1;
        drv(1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b1);
        gnt("lock_c", 2'b01);
        @(posedge clk); #1;
        drv(1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b0);
        gnt("lock_rel", 2'b01);
        @(posedge clk); #1;
        drv(1, 1'b0, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b0);
        gnt("after_rel", 2'b10);
        @(posedge clk); #1;
        m_read = '0;
        drain();

        // Byte-lane write merge
        issue(1, 1'b1, 16'h0020, 32'h0000AB00, 4'b0010);
        issue(1, 1'b0, 16'h0020, 32'h0, 4'hF);
        drain();
        chk("byte_merge", 64'(last_rd), 64'h1122AB44);

        // Reset pulse with a read in flight
        issue(0, 1'b0, 16'h0001, 32'h0, 4'hF);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drv(1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF, 1'b0);
        #1;
        chk("pulse_wr", 64'(m_waitrequest), 64'h3);
        chk("pulse_rdv", 64'(m_readdatavalid), 64'h0);
        chk("pulse_rdata", 64'(m_readdata), 64'h0);
        chk("pulse_cs", 64'(mem_chipselect), 64'h0);
        chk("pulse_we", 64'(mem_write), 64'h0);
        chk("pulse_addr", 64'(mem_address), 64'h0);
        chk("pulse_be", 64'(mem_byteenable), 64'h0);
        chk("pulse_wd", 64'(mem_writedata), 64'h0);
        chk("pulse_clken", 64'(mem_clken), 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drv(0, 1'b1, 1'b0, 16'h0001, 32'h0, 4'hF, 1'b0);
        gnt("post_rst_first", 2'b10);
        @(posedge clk); #1;
        gnt("post_rst_second", 2'b01);
        @(posedge clk); #1;
        m_read = '0;
        drain();
        repeat (4) @(negedge clk);
        chk("q_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
